// File: rtl/hs4_pkg.sv
// rtl/hs4_pkg.sv - shared types and reset constants for the four-phase bundled-data receiver
// Purpose : handshake FSM state type and the reset values used by the receiver.
// Contents: hs4_state_t {IDLE, ACK_HI}, STATE_RST, ACK_RST.
package hs4_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACK_HI = 1'b1
    } hs4_state_t;

    localparam hs4_state_t STATE_RST = IDLE;
    localparam logic       ACK_RST   = 1'b0;

endpackage

// File: rtl/hs4_bd_receiver_if.sv
// rtl/hs4_bd_receiver_if.sv - channel and stream bundle for the bundled-data receiver
// Purpose : groups the four-phase channel (req/data/ack), the output stream
//           (valid/data/ready) and the occupancy report.
// Modports: slave  - the receiver (drives ack_o, out_valid, out_data, level_o)
//           master - sender/consumer side (drives req_i, data_i, out_ready)
interface hs4_bd_receiver_if #(
    parameter int WD    = 8,
    parameter int DEPTH = 4
);
    localparam int LW = $clog2(DEPTH + 1);

    logic          req_i;
    logic [WD-1:0] data_i;
    logic          ack_o;
    logic          out_valid;
    logic [WD-1:0] out_data;
    logic          out_ready;
    logic [LW-1:0] level_o;

    modport slave (
        input  req_i,
        input  data_i,
        input  out_ready,
        output ack_o,
        output out_valid,
        output out_data,
        output level_o
    );

    modport master (
        output req_i,
        output data_i,
        output out_ready,
        input  ack_o,
        input  out_valid,
        input  out_data,
        input  level_o
    );

endinterface

// File: rtl/hs4_sync.sv
// rtl/hs4_sync.sv - N-flop synchroniser with asynchronous active-low reset to 0
// Purpose : brings an asynchronous level into the clk domain.
// Ports   : clk, rst_n, d (async input), q (synchronised output, last flop)
module hs4_sync #(
    parameter int N = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [N-1:0] ff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ff <= '0;
        end else begin
            ff <= {ff[N-2:0], d};
        end
    end

    assign q = ff[N-1];

endmodule

// File: rtl/hs4_bd_receiver.sv
// rtl/hs4_bd_receiver.sv - four-phase bundled-data receiver with output FIFO
// Purpose : synchronises req_i, captures data_i once per four-phase cycle,
//           returns ack_o and buffers words in a DEPTH-entry circular FIFO
//           drained through a valid/ready stream.
// Ports   : clk, rst_n (async, active low)
//           bus.req_i/data_i/ack_o       - four-phase bundled-data channel
//           bus.out_valid/out_data/out_ready - output stream (FIFO head)
//           bus.level_o                  - FIFO occupancy
module hs4_bd_receiver
    import hs4_pkg::*;
#(
    parameter int WD          = 8,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    hs4_bd_receiver_if.slave    bus
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);

    logic          req_s;
    hs4_state_t    state_q, state_d;
    logic          ack_q, ack_d;
    logic          push, pop, full;

    logic [WD-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [LW-1:0] level;

    hs4_sync #(.N(SYNC_STAGES)) u_req_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (bus.req_i),
        .q     (req_s)
    );

    // Full is taken from the registered level, so a pop on the same edge
    // cannot unblock a push until the following edge.
    assign full = (level == LW'(DEPTH));
    assign pop  = (level != '0) && bus.out_ready;

    always_comb begin
        state_d = state_q;
        push    = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_s && !full) begin
                    state_d = ACK_HI;
                    push    = 1'b1;
                end
            end
            ACK_HI: begin
                if (!req_s) begin
                    state_d = IDLE;
                end
            end
            default: state_d = STATE_RST;
        endcase
        ack_d = (state_d == ACK_HI);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= STATE_RST;
            ack_q   <= ACK_RST;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
        end
    end

    // Storage carries no reset; contents are only visible when level is non-zero.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    assign bus.ack_o     = ack_q;
    assign bus.out_valid = (level != '0);
    assign bus.out_data  = mem[rd_ptr];
    assign bus.level_o   = level;

endmodule

// File: tb/tb_hs4_bd_receiver.sv
// tb/tb_hs4_bd_receiver.sv - directed self-checking bench for hs4_bd_receiver
module tb_hs4_bd_receiver;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    logic chk_lvl = 1'b0;
    logic [7:0] sb [$];

    always #5 clk = ~clk;

    hs4_bd_receiver_if #(.WD(8), .DEPTH(4)) bus ();

    hs4_bd_receiver #(.WD(8), .DEPTH(4), .SYNC_STAGES(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full handshake on a non-full FIFO: ack rises and falls 3 edges after req.
    task automatic xfer(input logic [7:0] d);
        sb.push_back(d);
        bus.data_i = d;
        bus.req_i  = 1'b1;
        tick(); tick();
        chk("ack_early", {31'd0, bus.ack_o}, 32'd0);
        tick();
        chk("ack_rise", {31'd0, bus.ack_o}, 32'd1);
        bus.req_i = 1'b0;
        tick(); tick();
        chk("ack_hold", {31'd0, bus.ack_o}, 32'd1);
        tick();
        chk("ack_fall", {31'd0, bus.ack_o}, 32'd0);
    endtask

    task automatic drain(input int n);
        bus.out_ready = 1'b1;
        repeat (n) tick();
        bus.out_ready = 1'b0;
    endtask

    // Scoreboard: every accepted word must match the oldest expected word.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            chk("sb_nonempty", {31'd0, (sb.size() != 0)}, 32'd1);
            if (sb.size() != 0) begin
                chk("out_data", {24'd0, bus.out_data}, {24'd0, sb.pop_front()});
            end
        end
        if (chk_lvl) begin
            chk("level_le1", {31'd0, (bus.level_o <= 3'd1)}, 32'd1);
        end
    end

    initial begin
        bus.req_i     = 1'b0;
        bus.data_i    = 8'h00;
        bus.out_ready = 1'b0;
        tick(); tick();
        chk("rst_ack",   {31'd0, bus.ack_o},     32'd0);
        chk("rst_level", {29'd0, bus.level_o},   32'd0);
        chk("rst_valid", {31'd0, bus.out_valid}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Single transfer
        xfer(8'hA5);
        chk("single_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("single_data",  {24'd0, bus.out_data},  32'hA5);
        chk("single_level", {29'd0, bus.level_o},   32'd1);
        drain(1);
        chk("single_empty", {29'd0, bus.level_o}, 32'd0);

        // Fill with consumer stalled
        for (int i = 1; i <= 4; i++) xfer(8'(i));
        chk("fill_level", {29'd0, bus.level_o}, 32'd4);
        bus.data_i = 8'h05;
        bus.req_i  = 1'b1;
        repeat (6) tick();
        chk("full_noack",  {31'd0, bus.ack_o},   32'd0);
        chk("full_level",  {29'd0, bus.level_o}, 32'd4);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("pop_noack",  {31'd0, bus.ack_o},   32'd0);
        chk("pop_level",  {29'd0, bus.level_o}, 32'd3);
        sb.push_back(8'h05);
        tick();
        chk("late_ack",   {31'd0, bus.ack_o},   32'd1);
        chk("late_level", {29'd0, bus.level_o}, 32'd4);
        bus.req_i = 1'b0;
        repeat (3) tick();
        chk("late_fall", {31'd0, bus.ack_o}, 32'd0);
        drain(4);
        chk("fill_drained", {29'd0, bus.level_o}, 32'd0);

        // Wrap-around with free-running consumer
        bus.out_ready = 1'b1;
        chk_lvl = 1'b1;
        for (int i = 0; i < 10; i++) xfer(8'(8'h10 + i));
        tick();
        chk_lvl = 1'b0;
        bus.out_ready = 1'b0;
        chk("wrap_empty", {29'd0, bus.level_o}, 32'd0);
        chk("wrap_sb",    sb.size(),            32'd0);

        // Simultaneous push and pop at level 2
        xfer(8'h20);
        xfer(8'h21);
        chk("sim_level_pre", {29'd0, bus.level_o}, 32'd2);
        sb.push_back(8'h22);
        bus.data_i = 8'h22;
        bus.req_i  = 1'b1;
        tick(); tick();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("sim_ack",   {31'd0, bus.ack_o},   32'd1);
        chk("sim_level", {29'd0, bus.level_o}, 32'd2);
        bus.req_i = 1'b0;
        repeat (3) tick();
        drain(2);
        chk("sim_empty", {29'd0, bus.level_o}, 32'd0);

        // Reset mid-handshake with req still high
        xfer(8'h30);
        xfer(8'h31);
        bus.data_i = 8'h32;
        bus.req_i  = 1'b1;
        repeat (3) tick();
        chk("rr_ack_pre",   {31'd0, bus.ack_o},   32'd1);
        chk("rr_level_pre", {29'd0, bus.level_o}, 32'd3);
        rst_n = 1'b0;
        #1;
        chk("rr_ack",   {31'd0, bus.ack_o},     32'd0);
        chk("rr_level", {29'd0, bus.level_o},   32'd0);
        chk("rr_valid", {31'd0, bus.out_valid}, 32'd0);
        sb.delete();
        tick();
        rst_n = 1'b1;
        sb.push_back(8'h32);
        tick(); tick();
        chk("rr_ack_early", {31'd0, bus.ack_o}, 32'd0);
        tick();
        chk("rr_ack_rise", {31'd0, bus.ack_o},     32'd1);
        chk("rr_level1",   {29'd0, bus.level_o},   32'd1);
        chk("rr_data",     {24'd0, bus.out_data},  32'h32);
        bus.req_i = 1'b0;
        repeat (3) tick();
        chk("rr_fall", {31'd0, bus.ack_o}, 32'd0);
        drain(1);
        chk("end_sb",    sb.size(),            32'd0);
        chk("end_level", {29'd0, bus.level_o}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hs4_bd_receiver.md
# hs4_bd_receiver

Clocked receiving end of a four-phase return-to-zero bundled-data channel, used where circuits produced by the asynchronous synthesis flow hand data into synchronous logic. The block synchronises the incoming request, captures the bundled data word, completes the four-phase handshake, and buffers words in a small FIFO drained through a valid/ready stream. It is the counterpart to the asynchronous sender, which raises `req_i` with data and waits for `ack_o`.

## Interface
- `WD`, 8: data word width.
- `DEPTH`, 4: FIFO depth in words. Must be a power of two and ≥ 2.
- `SYNC_STAGES`, 2: number of flops in the request synchroniser. Must be ≥ 2.

- `clk` input 1: the block's only clock. All state changes on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `req_i` input 1: four-phase request from the asynchronous sender. Unsynchronised.
- `data_i` input WD: bundled data. Stable from before the `req_i` rise until `ack_o` is seen high.
- `ack_o` output 1: four-phase acknowledge. Registered.
- `out_valid` output 1: FIFO is non-empty.
- `out_data` output WD: FIFO head word. Valid when `out_valid` = 1.
- `out_ready` input 1: consumer accepts the head word.
- `level_o` output $clog2(DEPTH+1): current FIFO occupancy.

## Operation
- `req_i` passes through `SYNC_STAGES` flops; the last flop is `req_s`. `data_i` is not synchronised. The bundled-data timing rule guarantees it is stable for at least `SYNC_STAGES` cycles before `req_s` rises.
- FSM states:
  - IDLE: `ack_o` = 0.
  - ACK_HI: `ack_o` = 1.
- IDLE → ACK_HI when `req_s` = 1 and the FIFO is not full.
  - On that edge, `data_i` is pushed and `ack_o` is set to 1.
  - If `req_s` = 1 and the FIFO is full, stay in IDLE with no push. The sender stalls until space exists.
- ACK_HI → IDLE when `req_s` = 0. On that edge `ack_o` is cleared. `data_i` is ignored while in ACK_HI.
- Exactly one push per four-phase cycle. No push is possible while `req_s` stays high in ACK_HI.
- FIFO is a circular buffer:
  - Read and write pointers are `$clog2(DEPTH)` bits and wrap naturally.
  - Occupancy counter is `$clog2(DEPTH+1)` bits.
  - Full is `level_o` == DEPTH. Empty is `level_o` == 0.
- Pop occurs when `out_valid` and `out_ready` are both 1. `out_data` is the word at the read pointer, driven combinationally from storage.
- Push and pop on the same edge: the level is unchanged and both pointers advance.
- Full is evaluated before the edge, so a pop on the same edge does not unblock a push. The push happens on the next edge.
- Reset values:
  - `ack_o` = 0, FSM = IDLE.
  - All synchroniser flops = 0.
  - Pointers = 0, `level_o` = 0, `out_valid` = 0.
  - `out_data` is don't-care; storage is not reset.
- Reset mid-handshake:
  - A captured word still in the FIFO is lost.
  - If `req_i` is still high after reset, it is treated as a new transfer and the word is captured again. This is a documented duplicate; the sender must not rely on exactly-once delivery across a receiver reset.

## Timing
- Request rise to `ack_o` rise is `SYNC_STAGES` + 1 rising edges, with the FIFO not full. The default is 3.
- Request fall to `ack_o` fall is `SYNC_STAGES` + 1 edges.
- `out_valid` rises on the edge that performs the push. The word is available to the consumer on the following cycle.
- Throughput is at most one word per 2 × (`SYNC_STAGES` + 1) cycles plus sender delay. The FIFO absorbs consumer stalls.
- `out_ready` has no combinational path to `ack_o`. `ack_o` depends only on flops.

## Structure
- Package `hs4_pkg`:
  - State enum typedef `hs4_state_t` {IDLE, ACK_HI}.
  - Reset constants for the state and ack.
- Sub-module `hs4_sync`: a parameterised N-flop synchroniser with async active-low reset to 0. Reused by the future transmitter for `ack`.
- The FIFO stays inline. It is small and tightly coupled to the full check.

## Test plan
- Single transfer: `req_i` 0→1 with `data_i` = 0xA5.
  - `ack_o` rises 3 edges later.
  - `out_valid` = 1 and `out_data` = 0xA5.
  - Then `req_i` → 0 gives `ack_o` = 0 after 3 edges.
- Fill, with `out_ready` = 0: send 0x01..0x05.
  - Four words are acked and `level_o` = 4.
  - The fifth `req_i` stays unacked.
  - Raise `out_ready` for 1 cycle: 0x01 pops, and the fifth word is acked and pushed. Read order is 0x02..0x05.
- Wrap-around: send and drain 10 words 0x10..0x19 with `out_ready` = 1. The output sequence is exactly 0x10..0x19 and `level_o` ≤ 1 throughout.
- Simultaneous push and pop: start with `level_o` = 2. A push edge coincides with `out_ready` = 1. `level_o` stays 2 and the order is preserved.
- Reset mid-operation:
  - Assert `rst_n` = 0 while in ACK_HI with `level_o` = 3: `ack_o` = 0, `level_o` = 0 and `out_valid` = 0 immediately.
  - After release with `req_i` still high, the word is captured again and `ack_o` rises after 3 edges.
